// File: rtl/decode_issue_pkg.sv
// Shared definitions for the decode/issue stage and the crypto compute unit:
// operation codes, instruction field positions and the issue bundle layout.
package decode_issue_pkg;

  localparam int NUM_REGS = 16;

  // Instruction field LSB positions; every field is 4 bits except the 16-bit immediate.
  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP         = 4'd0;
  localparam logic [3:0] OP_SHA256_SIG0 = 4'd1;
  localparam logic [3:0] OP_SHA256_SIG1 = 4'd2;
  localparam logic [3:0] OP_SHA256_SUM0 = 4'd3;
  localparam logic [3:0] OP_SHA256_SUM1 = 4'd4;
  localparam logic [3:0] OP_AES_D_MID   = 4'd5;
  localparam logic [3:0] OP_AES_D_FINAL = 4'd6;
  localparam logic [3:0] OP_AES_E_MID   = 4'd7;
  localparam logic [3:0] OP_AES_E_FINAL = 4'd8;
  localparam logic [3:0] OP_LOAD_LLI    = 4'd9;
  localparam logic [3:0] OP_LOAD_LUI    = 4'd10;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [15:0] imm;
    logic [3:0]  rd;
  } issue_t;

  // Ops that produce a bundle for the compute unit (everything legal except NOP).
  function automatic logic is_issue_op(input logic [3:0] op);
    return (op != OP_NOP) && (op <= OP_LOAD_LUI);
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > OP_LOAD_LUI;
  endfunction

  // One-hot scoreboard mask; register 0 is never tracked.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [3:0] idx);
    if (idx == 4'd0) return '0;
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/decode_issue_regfile.sv
// 16x32 register file: two combinational read ports, one synchronous write
// port. Register 0 reads as zero and ignores writes.
module decode_issue_regfile
  import decode_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rs1_addr,
  input  logic [3:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] mem [NUM_REGS];

  // NOTE: the register file is cleared on reset because software expects every
  // register to read zero afterwards; this keeps it out of RAM macros on purpose.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_en && (wr_addr != 4'd0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = (rs1_addr == 4'd0) ? 32'd0 : mem[rs1_addr];
  assign rs2_data = (rs2_addr == 4'd0) ? 32'd0 : mem[rs2_addr];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes coprocessor instructions, reads operands with
// writeback forwarding, tracks RAW/WAW hazards and holds one issue bundle.
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [3:0]  iss_op,
  output logic [31:0] iss_rs1,
  output logic [31:0] iss_rs2,
  output logic [15:0] iss_imm,
  output logic [3:0]  iss_rd,
  input  logic        wb_valid,
  input  logic [3:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        illegal
);

  logic [3:0]  dec_op;
  logic [3:0]  dec_rd;
  logic [3:0]  dec_rs1;
  logic [3:0]  dec_rs2;
  logic [15:0] dec_imm;

  assign dec_op  = in_instr[OP_LSB  +: 4];
  assign dec_rd  = in_instr[RD_LSB  +: 4];
  assign dec_rs1 = in_instr[RS1_LSB +: 4];
  assign dec_rs2 = in_instr[RS2_LSB +: 4];
  assign dec_imm = in_instr[IMM_LSB +: 16];

  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;

  decode_issue_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (dec_rs1),
    .rs2_addr (dec_rs2),
    .rs1_data (rf_rs1),
    .rs2_data (rf_rs2),
    .wr_en    (wb_valid),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] wb_clear;
  logic [NUM_REGS-1:0] issue_set;
  logic [NUM_REGS-1:0] pending_eff;
  logic                hazard;
  logic                accept;
  logic                do_issue;
  logic [31:0]         opnd_rs1;
  logic [31:0]         opnd_rs2;
  issue_t              bundle;

  // Same-cycle writeback forwarding; reg 0 stays zero because the regfile already returns 0.
  function automatic logic [31:0] forward(input logic [3:0]  rs,
                                          input logic [31:0] rf_val,
                                          input logic        wv,
                                          input logic [3:0]  wr,
                                          input logic [31:0] wd);
    if (wv && (wr == rs) && (rs != 4'd0)) return wd;
    return rf_val;
  endfunction

  // NOTE: every signal driven from always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    wb_clear    = '0;
    issue_set   = '0;
    if (wb_valid) wb_clear = reg_mask(wb_rd);
    pending_eff = pending & ~wb_clear;
    hazard      = pending_eff[dec_rs1] | pending_eff[dec_rs2] | pending_eff[dec_rd];
    in_ready    = !hazard && (!iss_valid || iss_ready);
    accept      = in_valid && in_ready;
    do_issue    = accept && is_issue_op(dec_op);
    if (do_issue) issue_set = reg_mask(dec_rd);
    opnd_rs1    = forward(dec_rs1, rf_rs1, wb_valid, wb_rd, wb_data);
    opnd_rs2    = forward(dec_rs2, rf_rs2, wb_valid, wb_rd, wb_data);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      iss_valid <= 1'b0;
      illegal   <= 1'b0;
      bundle    <= '0;
    end else begin
      // Set is OR-ed in after the clear so a same-cycle set of the same bit wins.
      pending <= (pending & ~wb_clear) | issue_set;
      illegal <= accept && is_illegal_op(dec_op);
      if (do_issue) begin
        iss_valid  <= 1'b1;
        bundle.op  <= dec_op;
        bundle.rs1 <= opnd_rs1;
        bundle.rs2 <= opnd_rs2;
        bundle.imm <= dec_imm;
        bundle.rd  <= dec_rd;
      end else if (iss_ready) begin
        iss_valid <= 1'b0;
      end
    end
  end

  assign iss_op  = bundle.op;
  assign iss_rs1 = bundle.rs1;
  assign iss_rs2 = bundle.rs2;
  assign iss_imm = bundle.imm;
  assign iss_rd  = bundle.rd;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed hazard/backpressure/reset
// scenarios followed by randomized traffic, checked through a scoreboard.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        iss_valid;
  logic        iss_ready = 1'b1;
  logic [3:0]  iss_op;
  logic [31:0] iss_rs1;
  logic [31:0] iss_rs2;
  logic [15:0] iss_imm;
  logic [3:0]  iss_rd;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        illegal;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_op    (iss_op),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_imm   (iss_imm),
    .iss_rd    (iss_rd),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .illegal   (illegal)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [15:0] imm;
    logic [3:0]  rd;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  bit   exp_illegal = 1'b0;
  bit   mon_en = 1'b0;

  // Reference model state: architectural registers, busy flags, bundle occupancy.
  logic [31:0] m_regs [16];
  bit          m_busy [16];
  bit          m_valid;
  bit          m_accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1,
                                     input int rs2, input int imm);
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
  endfunction

  // Applies the instruction-level rules to what was driven during this cycle.
  task automatic model_step();
    logic [3:0]  op, rd, rs1, rs2;
    logic [31:0] v1, v2;
    bit          busy_now [16];
    bit          stall, ready, acc;
    op  = in_instr[31:28];
    rd  = in_instr[27:24];
    rs1 = in_instr[23:20];
    rs2 = in_instr[19:16];
    m_accepted = 1'b0;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      exp_q.delete();
      m_valid     = 1'b0;
      exp_illegal = 1'b0;
      return;
    end
    busy_now = m_busy;
    if (wb_valid) busy_now[wb_rd] = 1'b0;
    stall = busy_now[rs1] || busy_now[rs2] || busy_now[rd];
    ready = !stall && (!m_valid || iss_ready);
    check("in_ready", {31'd0, in_ready}, {31'd0, ready});
    acc = in_valid && ready;
    v1 = (rs1 == 0) ? 32'd0 : (wb_valid && wb_rd == rs1) ? wb_data : m_regs[rs1];
    v2 = (rs2 == 0) ? 32'd0 : (wb_valid && wb_rd == rs2) ? wb_data : m_regs[rs2];
    if (acc && op >= 1 && op <= 10) begin
      exp_q.push_back('{op: op, v1: v1, v2: v2, imm: in_instr[15:0], rd: rd});
      m_valid = 1'b1;
    end else if (iss_ready) begin
      m_valid = 1'b0;
    end
    if (wb_valid && wb_rd != 0) begin
      m_regs[wb_rd] = wb_data;
      m_busy[wb_rd] = 1'b0;
    end
    if (acc && op >= 1 && op <= 10 && rd != 0) m_busy[rd] = 1'b1;
    exp_illegal = acc && (op >= 11);
    m_accepted  = acc;
  endtask

  task automatic cycle(input bit r, input bit iv, input logic [31:0] ins, input bit ir,
                       input bit wv, input logic [3:0] wr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = iv;
    in_instr  = ins;
    iss_ready = ir;
    wb_valid  = wv;
    wb_rd     = wr;
    wb_data   = wd;
    @(negedge clk);
    #1;
    model_step();
  endtask

  // Monitor: compares what the DUT presents against the scoreboard queue.
  always @(negedge clk) begin
    if (mon_en) begin
      check("illegal", {31'd0, illegal}, {31'd0, exp_illegal});
      check("iss_valid", {31'd0, iss_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        check("iss_op",  {28'd0, iss_op},  {28'd0, exp_q[0].op});
        check("iss_rs1", iss_rs1,          exp_q[0].v1);
        check("iss_rs2", iss_rs2,          exp_q[0].v2);
        check("iss_imm", {16'd0, iss_imm}, {16'd0, exp_q[0].imm});
        check("iss_rd",  {28'd0, iss_rd},  {28'd0, exp_q[0].rd});
        if (iss_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] cur;
    bit          cur_v;
    int          busy_list[$];
    int          op;

    cycle(1, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0);
    check("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
    check("rst_illegal",   {31'd0, illegal},   32'd0);
    check("rst_iss_op",    {28'd0, iss_op},    32'd0);
    check("rst_iss_rs1",   iss_rs1,            32'd0);
    check("rst_iss_rs2",   iss_rs2,            32'd0);
    check("rst_iss_imm",   {16'd0, iss_imm},   32'd0);
    check("rst_iss_rd",    {28'd0, iss_rd},    32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    mon_en = 1'b1;

    for (int r = 1; r < 16; r++) cycle(0, 0, 0, 1, 1, 4'(r), 32'h1000_0000 + 32'(r * 17));

    // Back-to-back independent SIG0 ops, then retire them.
    cycle(0, 1, mk(1, 1, 2, 0, 0), 1, 0, 0, 0);
    cycle(0, 1, mk(1, 3, 4, 0, 0), 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 1, 32'h1111_1111);
    cycle(0, 0, 0, 1, 1, 3, 32'h3333_3333);

    // RAW on r2 resolved by a forwarded writeback.
    cycle(0, 1, mk(5, 2, 0, 0, 0), 1, 0, 0, 0);
    cycle(0, 1, mk(7, 6, 2, 0, 0), 1, 0, 0, 0);
    cycle(0, 1, mk(7, 6, 2, 0, 0), 1, 0, 0, 0);
    cycle(0, 1, mk(7, 6, 2, 0, 0), 1, 1, 2, 32'hDEAD_BEEF);
    cycle(0, 0, 0, 1, 1, 6, 32'h6666_6666);

    // Backpressure holds the bundle and blocks the next instruction.
    cycle(0, 1, mk(1, 9, 1, 3, 16'hABCD), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, mk(2, 10, 4, 5, 16'h0042), 0, 0, 0, 0);
    cycle(0, 1, mk(2, 10, 4, 5, 16'h0042), 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 9, 32'h9999_9999);
    cycle(0, 0, 0, 1, 1, 10, 32'hAAAA_AAAA);

    // Illegal op and NOP are consumed without issue.
    cycle(0, 1, mk(12, 5, 1, 2, 0), 1, 0, 0, 0);
    cycle(0, 1, mk(0, 5, 1, 2, 0), 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);

    // Register 0 is never busy and always reads zero.
    cycle(0, 1, mk(9, 0, 0, 0, 16'h1234), 1, 0, 0, 0);
    cycle(0, 1, mk(1, 11, 0, 0, 0), 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 32'hFFFF_FFFF);
    cycle(0, 1, mk(1, 12, 0, 0, 0), 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 11, 32'h0B0B_0B0B);
    cycle(0, 0, 0, 1, 1, 12, 32'h0C0C_0C0C);

    // Reset while stalled on a hazard, then the stalled instruction goes.
    cycle(0, 1, mk(5, 2, 0, 0, 0), 1, 0, 0, 0);
    cycle(0, 1, mk(7, 6, 2, 0, 0), 1, 0, 0, 0);
    cycle(0, 1, mk(7, 6, 2, 0, 0), 1, 0, 0, 0);
    cycle(1, 1, mk(7, 6, 2, 0, 0), 1, 0, 0, 0);
    cycle(0, 1, mk(7, 6, 2, 0, 0), 1, 1, 4, 32'h4444_4444);
    cycle(0, 0, 0, 1, 1, 6, 32'h6060_6060);

    // Randomized traffic with occasional resets.
    cur   = '0;
    cur_v = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bit          wv, ir, r;
      logic [3:0]  wr;
      if (!cur_v || m_accepted) begin
        cur_v = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 9))
          0:       op = 0;
          1:       op = $urandom_range(11, 15);
          default: op = $urandom_range(1, 10);
        endcase
        cur = mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 16'hFFFF));
      end
      busy_list.delete();
      for (int i = 0; i < 16; i++) if (m_busy[i]) busy_list.push_back(i);
      wv = ($urandom_range(0, 9) < 4);
      if (busy_list.size() != 0 && $urandom_range(0, 1) == 1)
        wr = 4'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      else
        wr = 4'($urandom_range(0, 15));
      ir = ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 299) == 0);
      cycle(r, cur_v, cur, ir, wv, wr, $urandom());
    end

    // Drain the bundle within a bounded number of cycles.
    for (int i = 0; i < 8 && m_valid; i++) cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
